mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between the instruction-cache refill path and the data-cache refill/writeback path of the Riscv151 pipeline.
- Accepts one line-sized request at a time from either cache and arbitrates round-robin.
- Issues the request to memory, then moves a fixed-length burst of data beats between memory and the owning cache.
- Sits between the two cache controllers and the memory model/top-level memory interface.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, width of one data beat
BEATS, 4, beats per cache line (power of two, >=2)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
ic_req_valid  in  1  icache refill request (read only)
ic_req_addr  in  ADDR_W  icache line byte address
ic_req_ready  out  1  icache request accepted this cycle
ic_resp_valid  out  1  icache read beat valid
ic_resp_data  out  DATA_W  icache read beat
ic_resp_last  out  1  final beat of icache burst
dc_req_valid  in  1  dcache request
dc_req_rw  in  1  1=write (writeback), 0=read (refill)
dc_req_addr  in  ADDR_W  dcache line byte address
dc_req_ready  out  1  dcache request accepted this cycle
dc_wdata_valid  in  1  dcache write beat valid
dc_wdata  in  DATA_W  dcache write beat
dc_wdata_ready  out  1  write beat consumed
dc_resp_valid  out  1  dcache read beat valid
dc_resp_data  out  DATA_W  dcache read beat
dc_resp_last  out  1  final beat of dcache burst
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_rw  out  1  1=write, 0=read
mem_req_addr  out  ADDR_W  line-aligned address
mem_wdata_valid  out  1  write beat to memory valid
mem_wdata  out  DATA_W  write beat to memory
mem_wdata_ready  in  1  memory accepts write beat
mem_resp_valid  in  1  read beat from memory
mem_resp_data  in  DATA_W  read beat data
busy  out  1  state != IDLE
owner  out  1  current/last grant: 0=icache, 1=dcache
err  out  1  sticky: mem_resp_valid seen outside RDATA

Behaviour:
- Reset (reset low, async): state=IDLE, beat counter=0, owner=0 (so dcache wins first tie), latched rw/addr=0, err=0. All valid/ready/last outputs are 0 during and after reset until IDLE logic drives them.
- States: IDLE, REQ, WDATA, RDATA.
- IDLE arbitration:
  - Only ic valid -> grant ic. Only dc valid -> grant dc.
  - Both valid -> grant the requester that is not the current owner (round-robin).
  - The granted requester's req_ready is 1 combinationally in the same cycle; the other is 0.
  - On grant: latch addr with low log2(BEATS*DATA_W/8) bits cleared, latch rw (ic forced 0), update owner, go to REQ.
  - req_ready is never 1 outside IDLE.
- REQ: mem_req_valid=1 with latched rw/addr, held stable until mem_req_ready. On handshake: rw=1 -> WDATA, rw=0 -> RDATA; counter cleared.
- WDATA (dc owner only):
  - mem_wdata_valid = dc_wdata_valid; mem_wdata = dc_wdata; dc_wdata_ready = mem_wdata_ready.
  - Each beat where both valid and ready are 1 increments the counter.
  - After the BEATS-th handshake -> IDLE. No response is returned for writes.
- RDATA:
  - Each mem_resp_valid is routed combinationally (zero latency) to the owner's resp_valid/resp_data and increments the counter.
  - resp_last=1 on the BEATS-th beat; next state is IDLE.
  - There is no backpressure; caches must accept every beat.
  - The non-owner's resp_valid stays 0.
- dc_wdata_ready is 0 outside WDATA.
- mem_resp_valid in IDLE/REQ/WDATA: beat is dropped and err set (cleared only by reset).
- Counter is log2(BEATS) bits and wraps to 0 on the last beat.
- Minimum transaction length:
  - Read: accept (1) + REQ (>=1) + BEATS beat cycles.
  - Write: 1 + >=1 + BEATS.
  - A new grant can occur on the cycle the FSM re-enters IDLE.
- A request deasserted while not granted is simply not served. Requesters must hold valid/addr stable until ready.
- Reset mid-burst aborts the transaction immediately. The memory side is reset by the same signal.

Test Plan:
- ic read only, addr 0x0000_1234, mem_req_ready=1, four resp beats 0xA0..0xA3 -> ic_req_ready cycle 0; mem_req_valid cycle 1, addr 0x0000_1230, rw=0; ic_resp_valid on 4 beats, ic_resp_last on 0xA3; dc_resp_valid stays 0; busy falls after last beat.
- Simultaneous ic and dc read after reset -> dc granted first (owner=1); after its burst, ic granted; repeat tie -> alternates dc, ic, dc.
- dc write 0x0000_2008, data 0x11..0x44, mem_wdata_ready toggling 1,0,1,0,... -> mem_req_addr 0x0000_2000, rw=1; exactly 4 beats transferred in order; no resp_valid; return to IDLE after the 4th handshake.
- mem_req_ready held 0 for 5 cycles -> mem_req_valid, addr and rw stable for all 5 cycles; no req_ready asserted to either cache.
- mem_resp_valid pulsed while in IDLE -> no resp_valid to either cache; err=1 and stays 1 until reset.
- reset asserted low after the 2nd read beat -> busy=0 and all valids=0 immediately; a fresh ic request after reset release completes a full 4-beat burst.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the two cache controllers, the memory port and the arbiter.
// The slave modport is the arbiter's view; master is the view of the caches and memory around it.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ic_req_valid;
    logic [ADDR_W-1:0] ic_req_addr;
    logic              ic_req_ready;
    logic              ic_resp_valid;
    logic [DATA_W-1:0] ic_resp_data;
    logic              ic_resp_last;

    logic              dc_req_valid;
    logic              dc_req_rw;
    logic [ADDR_W-1:0] dc_req_addr;
    logic              dc_req_ready;
    logic              dc_wdata_valid;
    logic [DATA_W-1:0] dc_wdata;
    logic              dc_wdata_ready;
    logic              dc_resp_valid;
    logic [DATA_W-1:0] dc_resp_data;
    logic              dc_resp_last;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_rw;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_wdata_valid;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wdata_ready;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    modport slave (
        input  ic_req_valid, ic_req_addr,
        output ic_req_ready, ic_resp_valid, ic_resp_data, ic_resp_last,
        input  dc_req_valid, dc_req_rw, dc_req_addr, dc_wdata_valid, dc_wdata,
        output dc_req_ready, dc_wdata_ready, dc_resp_valid, dc_resp_data, dc_resp_last,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_wdata_valid, mem_wdata,
        input  mem_req_ready, mem_wdata_ready, mem_resp_valid, mem_resp_data
    );

    modport master (
        output ic_req_valid, ic_req_addr,
        input  ic_req_ready, ic_resp_valid, ic_resp_data, ic_resp_last,
        output dc_req_valid, dc_req_rw, dc_req_addr, dc_wdata_valid, dc_wdata,
        input  dc_req_ready, dc_wdata_ready, dc_resp_valid, dc_resp_data, dc_resp_last,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_wdata_valid, mem_wdata,
        output mem_req_ready, mem_wdata_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one line-burst memory port between the icache refill path
// and the dcache refill/writeback path; one line transaction is in flight at a time.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BEATS  = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus,
    output logic              busy,
    output logic              owner,
    output logic              err
);
    localparam int CNT_W = $clog2(BEATS);
    localparam int OFF_W = $clog2(BEATS * DATA_W / 8);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic              owner_q, owner_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              grant_ic_s, grant_dc_s, last_beat_s;

    // Arbitration, burst sequencing and zero-latency routing between the caches and memory.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        owner_d     = owner_q;
        err_d       = err_q;
        grant_ic_s  = 1'b0;
        grant_dc_s  = 1'b0;
        last_beat_s = (cnt_q == CNT_W'(BEATS - 1));

        bus.ic_req_ready    = 1'b0;
        bus.ic_resp_valid   = 1'b0;
        bus.ic_resp_data    = {DATA_W{1'b0}};
        bus.ic_resp_last    = 1'b0;
        bus.dc_req_ready    = 1'b0;
        bus.dc_wdata_ready  = 1'b0;
        bus.dc_resp_valid   = 1'b0;
        bus.dc_resp_data    = {DATA_W{1'b0}};
        bus.dc_resp_last    = 1'b0;
        bus.mem_req_valid   = 1'b0;
        bus.mem_req_rw      = rw_q;
        bus.mem_req_addr    = addr_q;
        bus.mem_wdata_valid = 1'b0;
        bus.mem_wdata       = {DATA_W{1'b0}};

        // A read beat arriving outside a read burst has no destination: drop it and flag it.
        if (bus.mem_resp_valid && (state_q != RDATA)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end

        case (state_q)
            IDLE: begin
                if (bus.ic_req_valid && bus.dc_req_valid) begin
                    grant_dc_s = ~owner_q;
                    grant_ic_s = owner_q;
                end else begin
                    grant_dc_s = bus.dc_req_valid;
                    grant_ic_s = bus.ic_req_valid;
                end
                if (grant_dc_s) begin
                    bus.dc_req_ready = 1'b1;
                    addr_d  = {bus.dc_req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    rw_d    = bus.dc_req_rw;
                    owner_d = 1'b1;
                    state_d = REQ;
                end else if (grant_ic_s) begin
                    bus.ic_req_ready = 1'b1;
                    addr_d  = {bus.ic_req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    rw_d    = 1'b0;
                    owner_d = 1'b0;
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = rw_q ? WDATA : RDATA;
                end else begin
                    state_d = REQ;
                end
            end
            WDATA: begin
                bus.mem_wdata_valid = bus.dc_wdata_valid;
                bus.mem_wdata       = bus.dc_wdata;
                bus.dc_wdata_ready  = bus.mem_wdata_ready;
                if (bus.dc_wdata_valid && bus.mem_wdata_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = last_beat_s ? IDLE : WDATA;
                end else begin
                    state_d = WDATA;
                end
            end
            RDATA: begin
                if (bus.mem_resp_valid) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = last_beat_s ? IDLE : RDATA;
                    if (owner_q) begin
                        bus.dc_resp_valid = 1'b1;
                        bus.dc_resp_data  = bus.mem_resp_data;
                        bus.dc_resp_last  = last_beat_s;
                    end else begin
                        bus.ic_resp_valid = 1'b1;
                        bus.ic_resp_data  = bus.mem_resp_data;
                        bus.ic_resp_last  = last_beat_s;
                    end
                end else begin
                    state_d = RDATA;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, beat counter, latched request and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            addr_q  <= {ADDR_W{1'b0}};
            rw_q    <= 1'b0;
            owner_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            owner_q <= owner_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign busy  = busy_q;
    assign owner = owner_q;
    assign err   = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: the bench plays both caches and the memory,
// a line-level model predicts grant order and beat contents, and a monitor checks every output event.
module tb_mem_port_arbiter;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int BEATS      = 4;
    localparam int BYTES      = DATA_W / 8;
    localparam int LINE_BYTES = BEATS * BYTES;

    logic clk = 1'b0;
    logic reset;
    logic busy, owner, err;
    int   checks = 0;
    int   errors = 0;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy),
        .owner (owner),
        .err   (err)
    );

    always #5 clk = ~clk;

    // Scoreboard queues filled at issue time by the model.
    logic [ADDR_W:0]   exp_req_q[$];
    logic [DATA_W:0]   exp_ic_q[$];
    logic [DATA_W:0]   exp_dc_q[$];
    logic [DATA_W-1:0] exp_wr_q[$];
    logic [DATA_W-1:0] wq[$];
    logic [DATA_W-1:0] mem_arr [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] ref_arr [logic [ADDR_W-1:0]];
    bit                last_owner;

    // Bench-side memory and cache driver state.
    bit                rnd, inj_resp, wd_tog;
    int                hold_mreq, rd_left, rd_idx, wr_idx;
    logic [ADDR_W-1:0] rd_addr, wr_addr, s_mreq_addr;
    logic [DATA_W-1:0] s_wd_data;
    bit                s_ic_hs, s_dc_hs, s_mreq_hs, s_mreq_rw, s_wd_hs, s_resp_v;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexp(string name);
        checks++;
        errors++;
        $display("FAIL %s: event seen with nothing expected (got 1, required 0)", name);
    endtask

    function automatic logic [DATA_W-1:0] seed_word(logic [ADDR_W-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [DATA_W-1:0] mem_rd(logic [ADDR_W-1:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return seed_word(a);
    endfunction

    function automatic logic [DATA_W-1:0] ref_rd(logic [ADDR_W-1:0] a);
        if (ref_arr.exists(a)) return ref_arr[a];
        return seed_word(a);
    endfunction

    function automatic logic [ADDR_W-1:0] line_of(logic [ADDR_W-1:0] a);
        return a - (a % ADDR_W'(LINE_BYTES));
    endfunction

    task automatic model_ic(logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] l;
        l = line_of(a);
        exp_req_q.push_back({1'b0, l});
        for (int b = 0; b < BEATS; b++)
            exp_ic_q.push_back({b == BEATS - 1, ref_rd(l + ADDR_W'(b * BYTES))});
        last_owner = 1'b0;
    endtask

    task automatic model_dc(bit rw, logic [ADDR_W-1:0] a, bit fixed_wd);
        logic [ADDR_W-1:0] l;
        logic [DATA_W-1:0] d;
        l = line_of(a);
        exp_req_q.push_back({rw, l});
        for (int b = 0; b < BEATS; b++) begin
            if (rw) begin
                d = fixed_wd ? DATA_W'((b + 1) * 17) : DATA_W'($urandom);
                exp_wr_q.push_back(d);
                wq.push_back(d);
                ref_arr[l + ADDR_W'(b * BYTES)] = d;
            end else begin
                exp_dc_q.push_back({b == BEATS - 1, ref_rd(l + ADDR_W'(b * BYTES))});
            end
        end
        last_owner = 1'b1;
    endtask

    // Requests are issued only while the arbiter is idle, so a double request is a true tie.
    task automatic issue(bit ic_en, logic [ADDR_W-1:0] ic_a, bit dc_en, bit dc_rw,
                         logic [ADDR_W-1:0] dc_a, bit fixed_wd);
        bit dc_first;
        dc_first = dc_en && (!ic_en || !last_owner);
        if (dc_first) begin
            model_dc(dc_rw, dc_a, fixed_wd);
            if (ic_en) model_ic(ic_a);
        end else begin
            if (ic_en) model_ic(ic_a);
            if (dc_en) model_dc(dc_rw, dc_a, fixed_wd);
        end
        bus.ic_req_valid = ic_en;
        bus.ic_req_addr  = ic_a;
        bus.dc_req_valid = dc_en;
        bus.dc_req_rw    = dc_rw;
        bus.dc_req_addr  = dc_a;
    endtask

    // One clock of the cache and memory agents: sample handshakes at negedge, drive after posedge.
    task automatic step();
        @(negedge clk);
        s_ic_hs     = bus.ic_req_valid && bus.ic_req_ready;
        s_dc_hs     = bus.dc_req_valid && bus.dc_req_ready;
        s_mreq_hs   = bus.mem_req_valid && bus.mem_req_ready;
        s_mreq_rw   = bus.mem_req_rw;
        s_mreq_addr = bus.mem_req_addr;
        s_wd_hs     = bus.mem_wdata_valid && bus.mem_wdata_ready;
        s_wd_data   = bus.mem_wdata;
        s_resp_v    = bus.mem_resp_valid;
        @(posedge clk);
        #1;
        if (s_ic_hs) bus.ic_req_valid = 1'b0;
        if (s_dc_hs) bus.dc_req_valid = 1'b0;
        if (s_wd_hs) begin
            mem_arr[wr_addr + ADDR_W'(wr_idx * BYTES)] = s_wd_data;
            wr_idx++;
            if (wq.size() > 0) void'(wq.pop_front());
        end
        if (s_resp_v && rd_left > 0) begin
            rd_left--;
            rd_idx++;
        end
        if (s_mreq_hs) begin
            if (s_mreq_rw) begin
                wr_addr = s_mreq_addr;
                wr_idx  = 0;
            end else begin
                rd_addr = s_mreq_addr;
                rd_left = BEATS;
                rd_idx  = 0;
            end
        end
        wd_tog = ~wd_tog;
        if (hold_mreq > 0) begin
            bus.mem_req_ready = 1'b0;
            hold_mreq--;
        end else begin
            bus.mem_req_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
        end
        bus.mem_wdata_ready = rnd ? ($urandom_range(1) != 0) : wd_tog;
        bus.dc_wdata_valid  = (wq.size() > 0) && (!rnd || $urandom_range(3) != 0);
        bus.dc_wdata        = (wq.size() > 0) ? wq[0] : {DATA_W{1'b0}};
        bus.mem_resp_valid  = inj_resp || ((rd_left > 0) && (!rnd || $urandom_range(3) != 0));
        bus.mem_resp_data   = (rd_left > 0) ? mem_rd(rd_addr + ADDR_W'(rd_idx * BYTES)) : 32'hDEAD_BEEF;
        inj_resp = 1'b0;
    endtask

    task automatic wait_idle(string name, int budget);
        int n;
        n = 0;
        while (!(exp_req_q.size() == 0 && exp_ic_q.size() == 0 && exp_dc_q.size() == 0 &&
                 exp_wr_q.size() == 0 && !bus.ic_req_valid && !bus.dc_req_valid && !busy) &&
               n < budget) begin
            step();
            n++;
        end
        chk({"done_", name}, 64'(n >= budget), 64'd0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a request, beat or write transfer.
    initial begin : monitor
        logic            prev_stall;
        logic [ADDR_W:0] prev_req;
        prev_stall = 1'b0;
        prev_req   = {(ADDR_W + 1){1'b0}};
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    chk("req_hold", 64'({bus.mem_req_valid, bus.mem_req_rw, bus.mem_req_addr}),
                        64'({1'b1, prev_req}));
                if (busy)
                    chk("req_ready_busy", 64'({bus.ic_req_ready, bus.dc_req_ready}), 64'd0);
                if (bus.mem_req_valid && bus.mem_req_ready) begin
                    if (exp_req_q.size() == 0) unexp("mem_req");
                    else chk("mem_req", 64'({bus.mem_req_rw, bus.mem_req_addr}), 64'(exp_req_q.pop_front()));
                end
                if (bus.ic_resp_valid) begin
                    if (exp_ic_q.size() == 0) unexp("ic_resp");
                    else chk("ic_resp", 64'({bus.ic_resp_last, bus.ic_resp_data}), 64'(exp_ic_q.pop_front()));
                end
                if (bus.dc_resp_valid) begin
                    if (exp_dc_q.size() == 0) unexp("dc_resp");
                    else chk("dc_resp", 64'({bus.dc_resp_last, bus.dc_resp_data}), 64'(exp_dc_q.pop_front()));
                end
                if (bus.mem_wdata_valid && bus.mem_wdata_ready) begin
                    if (exp_wr_q.size() == 0) unexp("mem_wdata");
                    else chk("mem_wdata", 64'(bus.mem_wdata), 64'(exp_wr_q.pop_front()));
                end
                prev_stall = bus.mem_req_valid && !bus.mem_req_ready;
                prev_req   = {bus.mem_req_rw, bus.mem_req_addr};
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1;
        bus.ic_req_valid = 1'b0; bus.ic_req_addr = 32'h0;
        bus.dc_req_valid = 1'b0; bus.dc_req_rw = 1'b0; bus.dc_req_addr = 32'h0;
        bus.dc_wdata_valid = 1'b0; bus.dc_wdata = 32'h0;
        bus.mem_req_ready = 1'b0; bus.mem_wdata_ready = 1'b0;
        bus.mem_resp_valid = 1'b0; bus.mem_resp_data = 32'h0;
        rnd = 1'b0; inj_resp = 1'b0; wd_tog = 1'b0; hold_mreq = 0;
        rd_left = 0; rd_idx = 0; wr_idx = 0; rd_addr = 32'h0; wr_addr = 32'h0;
        last_owner = 1'b0;
        #1 reset = 1'b0;
        #1 chk("reset_state", 64'({busy, owner, err, bus.mem_req_valid, bus.ic_req_ready, bus.dc_req_ready,
                                   bus.ic_resp_valid, bus.dc_resp_valid, bus.dc_wdata_ready, bus.mem_wdata_valid}), 64'd0);
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;

        // Directed icache refill with known beats.
        for (int b = 0; b < BEATS; b++) begin
            mem_arr[32'h1230 + 32'(b * BYTES)] = 32'hA0 + 32'(b);
            ref_arr[32'h1230 + 32'(b * BYTES)] = 32'hA0 + 32'(b);
        end
        issue(1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'h0, 1'b0);
        #1 chk("ic_grant_c0", 64'({bus.ic_req_ready, bus.dc_req_ready, busy}), 64'(3'b100));
        step();
        #2 chk("req_c1", 64'({bus.mem_req_valid, bus.mem_req_rw, bus.mem_req_addr, busy}), 64'({1'b1, 1'b0, 32'h0000_1230, 1'b1}));
        step();
        repeat (BEATS - 1) step();
        #2 chk("busy_before_last", 64'(busy), 64'd1);
        step();
        #2 chk("busy_after_last", 64'(busy), 64'd0);
        wait_idle("ic_read", 50);

        // Ties: dcache wins while the last grant went to icache.
        issue(1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0204, 1'b0);
        #1 chk("tie1_dc_first", 64'({bus.dc_req_ready, bus.ic_req_ready}), 64'(2'b10));
        wait_idle("tie1", 100);
        chk("tie1_owner_ic", 64'(owner), 64'd0);
        issue(1'b1, 32'h0000_0308, 1'b1, 1'b0, 32'h0000_040C, 1'b0);
        #1 chk("tie2_dc_first", 64'({bus.dc_req_ready, bus.ic_req_ready}), 64'(2'b10));
        wait_idle("tie2", 100);

        // Directed writeback with memory ready toggling every cycle.
        issue(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_2008, 1'b1);
        #1 chk("wr_grant", 64'({bus.dc_req_ready, bus.ic_req_ready}), 64'(2'b10));
        wait_idle("write", 100);
        chk("wr_owner_dc", 64'(owner), 64'd1);

        // Memory request stalled for five cycles.
        hold_mreq = 5;
        issue(1'b1, 32'h0000_3454, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        for (int k = 0; k < 5; k++) begin
            #2 chk("stall_req", 64'({bus.mem_req_valid, bus.mem_req_rw, bus.mem_req_addr, bus.ic_req_ready, bus.dc_req_ready}),
                   64'({1'b1, 1'b0, 32'h0000_3450, 2'b00}));
            step();
        end
        wait_idle("stall", 100);

        // Randomized mixed traffic with backpressure and overlapping lines.
        rnd = 1'b1;
        for (int r = 0; r < 40; r++) begin
            bit ic_en, dc_en;
            ic_en = ($urandom_range(1) != 0);
            dc_en = !ic_en || ($urandom_range(1) != 0);
            hold_mreq = $urandom_range(2);
            issue(ic_en, ADDR_W'($urandom_range(255)), dc_en, $urandom_range(1) != 0,
                  ADDR_W'($urandom_range(255)), 1'b0);
            wait_idle("random", 400);
        end
        rnd = 1'b0;

        // Stray read beat in IDLE sets the sticky error.
        chk("err_clear", 64'(err), 64'd0);
        inj_resp = 1'b1;
        step();
        step();
        #2 chk("err_set", 64'(err), 64'd1);
        issue(1'b1, 32'h0000_0440, 1'b0, 1'b0, 32'h0, 1'b0);
        wait_idle("err_traffic", 50);
        chk("err_sticky", 64'(err), 64'd1);

        // Reset in the middle of a read burst, after two beats.
        issue(1'b1, 32'h0000_4444, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (4) step();
        reset = 1'b0;
        #1 chk("reset_abort", 64'({busy, bus.ic_resp_valid, bus.dc_resp_valid, bus.mem_req_valid,
                                   bus.ic_req_ready, bus.dc_req_ready, bus.mem_wdata_valid}), 64'd0);
        rd_left = 0; hold_mreq = 0; last_owner = 1'b0;
        bus.mem_resp_valid = 1'b0; bus.ic_req_valid = 1'b0; bus.dc_req_valid = 1'b0;
        exp_req_q.delete(); exp_ic_q.delete(); exp_dc_q.delete(); exp_wr_q.delete(); wq.delete();
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1 chk("reset_release", 64'({busy, owner, err}), 64'd0);
        issue(1'b1, 32'h0000_5550, 1'b0, 1'b0, 32'h0, 1'b0);
        wait_idle("after_reset", 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
